flit_packer: RTL and testbench
==============================

// Module: flit_packer
// PURPOSE
//   Downstream stage of the flit compressor. Takes variable-length compressed payloads (LSB-aligned, with a
//   bit count) and packs them densely, LSB-first, into fixed-width output flits for the NoC link.
//   Valid/ready handshake on both sides; a 2*FLIT_W-bit accumulator absorbs length mismatch.
//   in_last flushes the partial final flit of a packet.
// PARAMETERS
//   FLIT_W  128  output flit width in bits
//   IN_W    128  max compressed payload width per input beat
//   LEN_W   9    width of length/count fields; must hold 2*FLIT_W (256)
// PORTS
//   clk        in   1       clock, rising edge
//   rst        in   1       synchronous reset, active-high
//   in_valid   in   1       input beat valid
//   in_ready   out  1       packer can accept a beat this cycle
//   in_data    in   IN_W    compressed payload, bits [in_len-1:0] meaningful
//   in_len     in   LEN_W   payload bit count, 0..IN_W
//   in_last    in   1       beat is final beat of packet; triggers flush
//   out_valid  out  1       output flit valid
//   out_ready  in   1       consumer accepts flit this cycle
//   out_data   out  FLIT_W  packed flit, bits at or above out_bits are zero
//   out_bits   out  LEN_W   meaningful bits in out_data (FLIT_W except final partial flit)
//   out_last   out  1       flit carries final bit of packet
// BEHAVIOUR
//   - Internal state: buf[2*FLIT_W-1:0], fill (0..2*FLIT_W), flush_pend (1 bit).
//   - Reset (rst=1 at posedge): buf=0, fill=0, flush_pend=0. Outputs in the following cycle: out_valid=0,
//     out_data=0, out_bits=0, out_last=0, in_ready=1. While rst is high: in_ready=0, out_valid=0.
//     Reset mid-packet discards all buffered bits; no partial flit is emitted.
//   - in_ready = !flush_pend && (fill <= 2*FLIT_W - IN_W). With the default parameters this is fill <= 128.
//   - Input handshake: in_valid && in_ready. in_len > IN_W is clamped to IN_W. in_data bits at or above
//     in_len are masked to 0 before insertion.
//   - out_valid = (fill >= FLIT_W) || (flush_pend && !in_handshake_pending).
//     out_data = buf[FLIT_W-1:0], masked above out_bits.
//     out_bits = min(fill, FLIT_W).
//     out_last = flush_pend && (fill <= FLIT_W).
//   - Output handshake: out_valid && out_ready. Emits e = out_bits. buf is shifted right by e, and
//     fill -= e. When out_last is handshaked, flush_pend clears.
//   - Simultaneous in and out handshake in one cycle: shift first, then place the new payload at bit
//     position (fill - e). Result: fill_next = fill - e + in_len.
//   - in_last accepted: payload is appended and flush_pend is set. in_ready stays 0 until the out_last flit
//     is handshaked.
//   - Full flits ahead of the final one are emitted with out_last=0. The final flit may be exactly FLIT_W
//     bits; it then carries out_bits=FLIT_W and out_last=1.
//   - Empty packet (in_last with fill=0 and in_len=0): one flit with out_bits=0, out_data=0, out_last=1.
//   - Latency: a beat accepted at edge N appears at the output no earlier than the cycle after N.
//     Outputs are driven from registered state only; no combinational in->out path.
//   - Stall: while out_valid && !out_ready, out_data, out_bits and out_last hold stable.
//   - in_len=0 without in_last: accepted, no state change.
//   - fill never exceeds 2*FLIT_W. Any overflow is a design bug; flag it with an assertion.
// TESTING
//   1 Four beats of len 32 (0x11111111, 0x22222222, 0x33333333, 0x44444444), last on the 4th ->
//     one flit 128'h44444444_33333333_22222222_11111111, out_bits=128, out_last=1.
//   2 Beat 64'hFAC68915ACEF098F len 64, then 64'hDEADBEEF00C0FFEE len 64 with last ->
//     out_data=128'hDEADBEEF00C0FFEE_FAC68915ACEF098F, out_bits=128, out_last=1.
//   3 out_ready=0; offer three 100-bit beats -> first two accepted (fill 0->100->200), then in_ready=0;
//     out_data holds the low 128 bits stable; releasing out_ready drains 128 bits (fill 72) and
//     in_ready returns to 1.
//   4 Single beat 20'hABCDE len 20 with last -> out_data=128'h...0ABCDE, out_bits=20, out_last=1,
//     in_ready=0 until that flit is handshaked.
//   5 fill=150, out_ready=1, accept a 60-bit beat in the same cycle -> 128-bit flit emitted,
//     fill_next=82, new bits at positions [81:22].
//   6 rst asserted with fill=90 and flush_pend=0 -> next cycle out_valid=0 and fill=0; the next packet
//     packs from bit 0.

Source files
------------

// File: rtl/flit_packer.sv
// rtl/flit_packer.sv - packs variable-length compressed payloads LSB-first into fixed-width flits
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   in_valid/in_ready    input beat handshake
//   in_data, in_len      LSB-aligned payload and its bit count (clamped to IN_W)
//   in_last              final beat of packet; forces the partial tail flit out
//   out_valid/out_ready  output flit handshake
//   out_data, out_bits   packed flit and its meaningful bit count (zero above out_bits)
//   out_last             flit carries the final bit of the packet
module flit_packer #(
    parameter int FLIT_W = 128,
    parameter int IN_W   = 128,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic [LEN_W-1:0]  in_len,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FLIT_W-1:0] out_data,
    output logic [LEN_W-1:0]  out_bits,
    output logic              out_last
);

    localparam int BUF_W = 2 * FLIT_W;

    localparam logic [LEN_W-1:0] FLIT_LEN = LEN_W'(FLIT_W);
    localparam logic [LEN_W-1:0] IN_LEN   = LEN_W'(IN_W);
    localparam logic [LEN_W-1:0] BUF_LEN  = LEN_W'(BUF_W);
    // Highest fill at which a maximum-length beat still fits in the buffer.
    localparam logic [LEN_W-1:0] IN_LIMIT = LEN_W'(BUF_W - IN_W);

    logic [BUF_W-1:0] data_buf;
    logic [LEN_W-1:0] fill;
    logic             flush_pend;

    logic [BUF_W-1:0] data_buf_next;
    logic [LEN_W-1:0] fill_next;
    logic             flush_pend_next;

    logic [LEN_W-1:0] head_bits;
    logic [LEN_W-1:0] in_len_c;
    logic [IN_W-1:0]  in_masked;
    logic [LEN_W-1:0] emit;
    logic [LEN_W-1:0] base;
    logic             in_fire;
    logic             out_fire;

    // Output side is a pure function of registered state (plus rst gating).
    always_comb begin
        head_bits = (fill >= FLIT_LEN) ? FLIT_LEN : fill;
        in_ready  = !rst && !flush_pend && (fill <= IN_LIMIT);
        // While a flush is pending in_ready is low, so no beat can still be
        // in flight toward the tail flit; flush_pend alone releases it.
        out_valid = !rst && ((fill >= FLIT_LEN) || flush_pend);
        out_bits  = head_bits;
        out_last  = flush_pend && (fill <= FLIT_LEN);
        out_data  = data_buf[FLIT_W-1:0] & ~({FLIT_W{1'b1}} << head_bits);
    end

    always_comb begin
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        in_len_c  = (in_len > IN_LEN) ? IN_LEN : in_len;
        // Shifting by IN_W yields zero, so a full-width beat keeps every bit.
        in_masked = in_data & ~({IN_W{1'b1}} << in_len_c);
        emit      = out_fire ? head_bits : '0;
        // Drain first, then land the new payload just above what remains.
        base      = fill - emit;

        data_buf_next = data_buf >> emit;
        fill_next     = base;
        if (in_fire) begin
            data_buf_next = data_buf_next | (BUF_W'(in_masked) << base);
            fill_next     = base + in_len_c;
        end

        flush_pend_next = flush_pend;
        if (out_fire && out_last) begin
            flush_pend_next = 1'b0;
        end
        if (in_fire && in_last) begin
            flush_pend_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_buf   <= '0;
            fill       <= '0;
            flush_pend <= 1'b0;
        end else begin
            data_buf   <= data_buf_next;
            fill       <= fill_next;
            flush_pend <= flush_pend_next;
        end
    end

    fill_bound : assert property (@(posedge clk) disable iff (rst) fill_next <= BUF_LEN);

endmodule

// File: tb/tb_flit_packer.sv
// tb/tb_flit_packer.sv - directed self-checking bench for flit_packer
module tb_flit_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [8:0]   in_len;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [8:0]   out_bits;
    logic         out_last;

    logic         n_in_valid;
    logic         n_in_ready;
    logic [63:0]  n_in_data;
    logic [8:0]   n_in_len;
    logic         n_in_last;
    logic         n_out_valid;
    logic         n_out_ready;
    logic [127:0] n_out_data;
    logic [8:0]   n_out_bits;
    logic         n_out_last;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    flit_packer #(.FLIT_W(128), .IN_W(128), .LEN_W(9)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_len(in_len), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bits(out_bits), .out_last(out_last)
    );

    flit_packer #(.FLIT_W(128), .IN_W(64), .LEN_W(9)) dut_narrow (
        .clk(clk), .rst(rst),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
        .in_len(n_in_len), .in_last(n_in_last),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
        .out_bits(n_out_bits), .out_last(n_out_last)
    );

    task automatic send(input logic [127:0] d, input logic [8:0] l, input logic last,
                        output logic ok);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_len = l; in_last = last;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        if (ok) @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic take(output logic ok, output logic [127:0] d, output logic [8:0] b,
                        output logic l);
        int n = 0;
        @(negedge clk);
        out_ready = 1'b1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = out_valid; d = out_data; b = out_bits; l = out_last;
        if (ok) @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_len = '0; in_last = 1'b0; out_ready = 1'b0;
        n_in_valid = 1'b0; n_in_data = '0; n_in_len = '0; n_in_last = 1'b0; n_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_hold_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_hold_out_valid got %b want 0", out_valid); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 128'h0) begin fails++; $display("FAIL rst_out_data got %h want 0", out_data); end
        checks++; if (out_bits !== 9'd0) begin fails++; $display("FAIL rst_out_bits got %0d want 0", out_bits); end
        checks++; if (out_last !== 1'b0) begin fails++; $display("FAIL rst_out_last got %b want 0", out_last); end
        checks++; if (n_in_ready !== 1'b1) begin fails++; $display("FAIL rst_narrow_in_ready got %b want 1", n_in_ready); end
    endtask

    task automatic test_four_beats;
        logic ok, all_ok, l;
        logic [127:0] d;
        logic [8:0] b;
        all_ok = 1'b1;
        send(128'h11111111, 9'd32, 1'b0, ok); all_ok &= ok;
        send(128'h22222222, 9'd32, 1'b0, ok); all_ok &= ok;
        send(128'h33333333, 9'd32, 1'b0, ok); all_ok &= ok;
        send(128'h44444444, 9'd32, 1'b1, ok); all_ok &= ok;
        checks++; if (all_ok !== 1'b1) begin fails++; $display("FAIL t1_accept got %b want 1", all_ok); end
        take(ok, d, b, l);
        checks++; if (ok !== 1'b1) begin fails++; $display("FAIL t1_valid got %b want 1", ok); end
        checks++; if (d !== 128'h44444444_33333333_22222222_11111111) begin fails++; $display("FAIL t1_data got %h want 44444444333333332222222211111111", d); end
        checks++; if (b !== 9'd128) begin fails++; $display("FAIL t1_bits got %0d want 128", b); end
        checks++; if (l !== 1'b1) begin fails++; $display("FAIL t1_last got %b want 1", l); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL t1_ready_after got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t1_idle_valid got %b want 0", out_valid); end
    endtask

    task automatic test_two_beats;
        logic ok, all_ok, l;
        logic [127:0] d;
        logic [8:0] b;
        all_ok = 1'b1;
        send(128'hFAC68915ACEF098F, 9'd64, 1'b0, ok); all_ok &= ok;
        send(128'hDEADBEEF00C0FFEE, 9'd64, 1'b1, ok); all_ok &= ok;
        checks++; if (all_ok !== 1'b1) begin fails++; $display("FAIL t2_accept got %b want 1", all_ok); end
        take(ok, d, b, l);
        checks++; if (ok !== 1'b1) begin fails++; $display("FAIL t2_valid got %b want 1", ok); end
        checks++; if (d !== 128'hDEADBEEF00C0FFEE_FAC68915ACEF098F) begin fails++; $display("FAIL t2_data got %h want DEADBEEF00C0FFEEFAC68915ACEF098F", d); end
        checks++; if (b !== 9'd128) begin fails++; $display("FAIL t2_bits got %0d want 128", b); end
        checks++; if (l !== 1'b1) begin fails++; $display("FAIL t2_last got %b want 1", l); end
    endtask

    task automatic test_stall;
        logic ok, all_ok, l;
        logic [127:0] d, a_val, b_val;
        logic [8:0] b;
        logic [255:0] packed_v;
        a_val = 128'hA_5A5A5A5A_5A5A5A5A_5A5A5A5A;
        b_val = 128'h3_01234567_89ABCDEF_01234567;
        packed_v = 256'(a_val) | (256'(b_val) << 100);
        all_ok = 1'b1;
        send(a_val, 9'd100, 1'b0, ok); all_ok &= ok;
        send(b_val, 9'd100, 1'b0, ok); all_ok &= ok;
        checks++; if (all_ok !== 1'b1) begin fails++; $display("FAIL t3_accept got %b want 1", all_ok); end
        @(negedge clk);
        in_valid = 1'b1; in_data = 128'h7; in_len = 9'd100; in_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL t3_full_ready[%0d] got %b want 0", i, in_ready); end
            checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL t3_stall_valid[%0d] got %b want 1", i, out_valid); end
            checks++; if (out_data !== packed_v[127:0]) begin fails++; $display("FAIL t3_stall_data[%0d] got %h want %h", i, out_data, packed_v[127:0]); end
            checks++; if (out_bits !== 9'd128) begin fails++; $display("FAIL t3_stall_bits[%0d] got %0d want 128", i, out_bits); end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++; if (out_bits !== 9'd72) begin fails++; $display("FAIL t3_remaining got %0d want 72", out_bits); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t3_partial_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL t3_ready_back got %b want 1", in_ready); end
        send(128'h0, 9'd0, 1'b1, ok);
        take(ok, d, b, l);
        checks++; if (ok !== 1'b1) begin fails++; $display("FAIL t3_tail_valid got %b want 1", ok); end
        checks++; if (d !== packed_v[255:128]) begin fails++; $display("FAIL t3_tail_data got %h want %h", d, packed_v[255:128]); end
        checks++; if (b !== 9'd72) begin fails++; $display("FAIL t3_tail_bits got %0d want 72", b); end
        checks++; if (l !== 1'b1) begin fails++; $display("FAIL t3_tail_last got %b want 1", l); end
    endtask

    task automatic test_single_last;
        logic ok, l;
        logic [127:0] d, src;
        logic [8:0] b;
        src = '1;
        src[19:0] = 20'hABCDE;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t4_pre_valid got %b want 0", out_valid); end
        send(src, 9'd20, 1'b1, ok);
        checks++; if (ok !== 1'b1) begin fails++; $display("FAIL t4_accept got %b want 1", ok); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL t4_ready_blocked[%0d] got %b want 0", i, in_ready); end
            checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL t4_valid[%0d] got %b want 1", i, out_valid); end
        end
        take(ok, d, b, l);
        checks++; if (d !== 128'hABCDE) begin fails++; $display("FAIL t4_data got %h want 000ABCDE", d); end
        checks++; if (b !== 9'd20) begin fails++; $display("FAIL t4_bits got %0d want 20", b); end
        checks++; if (l !== 1'b1) begin fails++; $display("FAIL t4_last got %b want 1", l); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL t4_ready_after got %b want 1", in_ready); end
    endtask

    task automatic test_full_then_last;
        logic ok, all_ok, l;
        logic [127:0] d;
        logic [8:0] b;
        all_ok = 1'b1;
        send(128'hC3C3C3C3_00000001_00000002_00000003, 9'd128, 1'b0, ok); all_ok &= ok;
        send(128'h0F0F0F0F_10000000_20000000_30000000, 9'd128, 1'b0, ok); all_ok &= ok;
        checks++; if (all_ok !== 1'b1) begin fails++; $display("FAIL tf_accept got %b want 1", all_ok); end
        take(ok, d, b, l);
        checks++; if (d !== 128'hC3C3C3C3_00000001_00000002_00000003 || b !== 9'd128 || l !== 1'b0) begin fails++; $display("FAIL tf_first got %h/%0d/%b want C3C3C3C3000000010000000200000003/128/0", d, b, l); end
        send(128'hFFFF_FF5C, 9'd8, 1'b1, ok);
        checks++; if (ok !== 1'b1) begin fails++; $display("FAIL tf_last_accept got %b want 1", ok); end
        take(ok, d, b, l);
        checks++; if (d !== 128'h0F0F0F0F_10000000_20000000_30000000 || b !== 9'd128 || l !== 1'b0) begin fails++; $display("FAIL tf_second got %h/%0d/%b want 0F0F0F0F100000002000000030000000/128/0", d, b, l); end
        take(ok, d, b, l);
        checks++; if (d !== 128'h5C || b !== 9'd8 || l !== 1'b1) begin fails++; $display("FAIL tf_tail got %h/%0d/%b want 5C/8/1", d, b, l); end
    endtask

    task automatic test_clamp;
        logic ok, l;
        logic [127:0] d;
        logic [8:0] b;
        send('1, 9'd200, 1'b0, ok);
        take(ok, d, b, l);
        checks++; if (ok !== 1'b1) begin fails++; $display("FAIL clamp_valid got %b want 1", ok); end
        checks++; if (d !== {128{1'b1}} || b !== 9'd128 || l !== 1'b0) begin fails++; $display("FAIL clamp_flit got %h/%0d/%b want all-ones/128/0", d, b, l); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_bits !== 9'd0) begin fails++; $display("FAIL clamp_empty got %b/%0d want 0/0", out_valid, out_bits); end
    endtask

    task automatic test_empty_packet;
        logic ok, l;
        logic [127:0] d;
        logic [8:0] b;
        send(128'hDEAD, 9'd0, 1'b0, ok);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_bits !== 9'd0 || in_ready !== 1'b1) begin fails++; $display("FAIL zero_len got %b/%0d/%b want 0/0/1", out_valid, out_bits, in_ready); end
        send(128'hBEEF, 9'd0, 1'b1, ok);
        take(ok, d, b, l);
        checks++; if (ok !== 1'b1) begin fails++; $display("FAIL empty_valid got %b want 1", ok); end
        checks++; if (d !== 128'h0 || b !== 9'd0 || l !== 1'b1) begin fails++; $display("FAIL empty_flit got %h/%0d/%b want 0/0/1", d, b, l); end
    endtask

    task automatic test_simultaneous;
        logic [63:0]  nd [3];
        logic [8:0]   nl [3];
        logic [127:0] exp_tail;
        nd[0] = 64'h0123456789ABCDEF; nl[0] = 9'd64;
        nd[1] = 64'hFEDCBA9876543210; nl[1] = 9'd64;
        nd[2] = 64'hFFFFFFFFFFEAAAAA; nl[2] = 9'd22;
        exp_tail = 128'h0C0FFEE123456789;
        exp_tail = (exp_tail << 22) | 128'h2AAAAA;
        n_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_in_valid = 1'b1; n_in_data = nd[i]; n_in_len = nl[i]; n_in_last = 1'b0;
            checks++; if (n_in_ready !== 1'b1) begin fails++; $display("FAIL t5_fill_ready[%0d] got %b want 1", i, n_in_ready); end
            @(posedge clk);
            #1;
            n_in_valid = 1'b0;
        end
        @(negedge clk);
        n_out_ready = 1'b1;
        n_in_valid = 1'b1; n_in_data = 64'hFC0FFEE123456789; n_in_len = 9'd60;
        checks++; if (n_in_ready !== 1'b1 || n_out_valid !== 1'b1) begin fails++; $display("FAIL t5_both_ready got %b/%b want 1/1", n_in_ready, n_out_valid); end
        checks++; if (n_out_data !== 128'hFEDCBA9876543210_0123456789ABCDEF || n_out_bits !== 9'd128 || n_out_last !== 1'b0) begin fails++; $display("FAIL t5_flit got %h/%0d/%b want FEDCBA98765432100123456789ABCDEF/128/0", n_out_data, n_out_bits, n_out_last); end
        @(posedge clk);
        #1;
        n_out_ready = 1'b0; n_in_valid = 1'b0;
        @(negedge clk);
        checks++; if (n_out_bits !== 9'd82 || n_out_valid !== 1'b0) begin fails++; $display("FAIL t5_fill_next got %0d/%b want 82/0", n_out_bits, n_out_valid); end
        n_in_valid = 1'b1; n_in_len = 9'd0; n_in_last = 1'b1;
        checks++; if (n_in_ready !== 1'b1) begin fails++; $display("FAIL t5_last_ready got %b want 1", n_in_ready); end
        @(posedge clk);
        #1;
        n_in_valid = 1'b0; n_in_last = 1'b0;
        @(negedge clk);
        checks++; if (n_out_valid !== 1'b1 || n_out_bits !== 9'd82 || n_out_last !== 1'b1) begin fails++; $display("FAIL t5_tail_ctl got %b/%0d/%b want 1/82/1", n_out_valid, n_out_bits, n_out_last); end
        checks++; if (n_out_data !== exp_tail) begin fails++; $display("FAIL t5_tail_data got %h want %h", n_out_data, exp_tail); end
        n_out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_out_ready = 1'b0;
        @(negedge clk);
        checks++; if (n_out_valid !== 1'b0 || n_in_ready !== 1'b1) begin fails++; $display("FAIL t5_done got %b/%b want 0/1", n_out_valid, n_in_ready); end
    endtask

    task automatic test_reset_mid;
        logic ok, l;
        logic [127:0] d;
        logic [8:0] b;
        send(128'h3FF_FFFFFFFF_12345678_9ABCDEF0, 9'd90, 1'b0, ok);
        @(negedge clk);
        checks++; if (out_bits !== 9'd90 || out_valid !== 1'b0) begin fails++; $display("FAIL t6_pre got %0d/%b want 90/0", out_bits, out_valid); end
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL t6_during got %b/%b want 0/0", in_ready, out_valid); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_bits !== 9'd0 || out_data !== 128'h0 || in_ready !== 1'b1) begin fails++; $display("FAIL t6_after got %b/%0d/%h/%b want 0/0/0/1", out_valid, out_bits, out_data, in_ready); end
        send(128'hBEEF, 9'd16, 1'b1, ok);
        take(ok, d, b, l);
        checks++; if (ok !== 1'b1 || d !== 128'hBEEF || b !== 9'd16 || l !== 1'b1) begin fails++; $display("FAIL t6_repack got %b/%h/%0d/%b want 1/BEEF/16/1", ok, d, b, l); end
    endtask

    initial begin
        test_reset;
        test_four_beats;
        test_two_beats;
        test_stall;
        test_single_last;
        test_full_then_last;
        test_clamp;
        test_empty_packet;
        test_simultaneous;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
